// File: rtl/fixed_point_mac.sv
// rtl/fixed_point_mac.sv - signed Q16.16 pipelined multiply-accumulate
//
// Purpose:
//   Every clock, multiplies data_in_a by data_in_b (both signed Q16.16),
//   rounds the Q32.32 product half-up to Q32.16, and adds it into a running
//   ACC_W-bit accumulator. The accumulated sum is presented on data_out as
//   signed Q16.16 through one further register stage. There is no enable and
//   no handshake: the sum only changes through its inputs or through reset.
//
// Pipeline:
//   edge N   : operands -> prod_q (rounded product)
//   edge N+1 : acc_q <= acc_q + prod_q
//   edge N+2 : data_out <= acc_q (truncated or clamped)
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-low reset (0 = in reset)
//   data_in_a  in   WIDTH  operand A, signed Q16.16
//   data_in_b  in   WIDTH  operand B, signed Q16.16
//   data_out   out  WIDTH  accumulated sum, signed Q16.16, registered
//
// Build option:
//   MAC_SATURATE_EN  defined   : accumulator saturates at ACC_W signed bounds,
//                                data_out clamps to the WIDTH-bit signed range.
//                    undefined : accumulator wraps modulo 2^ACC_W,
//                                data_out is the low WIDTH bits of acc_q.

module fixed_point_mac #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int ACC_W = 2*WIDTH - FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in_a,
  input  logic [WIDTH-1:0] data_in_b,
  output logic [WIDTH-1:0] data_out
);

  localparam int PW = 2*WIDTH;

  // Half of one output LSB, added before the shift for round-half-up.
  localparam logic [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC-1);

  // ---------------------------------------------------------------------
  // Stage 1: full-precision signed multiply and rounding
  // ---------------------------------------------------------------------
  logic signed [PW-1:0]    a_ext;
  logic signed [PW-1:0]    b_ext;
  logic signed [PW-1:0]    prod_full;
  logic signed [PW-1:0]    prod_rnd;
  logic signed [ACC_W-1:0] prod_d;
  logic signed [ACC_W-1:0] prod_q;

  // Sign-extend explicitly so the multiply is carried out at full product
  // width; the low PW bits of a PW x PW multiply are the exact signed product.
  assign a_ext     = {{WIDTH{data_in_a[WIDTH-1]}}, data_in_a};
  assign b_ext     = {{WIDTH{data_in_b[WIDTH-1]}}, data_in_b};
  assign prod_full = a_ext * b_ext;

  // The largest magnitude product, (-2^31)^2 = 2^62, plus the rounding
  // constant still fits PW signed bits, so this add cannot overflow.
  assign prod_rnd  = prod_full + $signed(RND);

  // Arithmetic shift drops the fraction bits; the remaining value always
  // fits ACC_W signed bits (worst case 2^46).
  assign prod_d    = ACC_W'(prod_rnd >>> FRAC);

  // ---------------------------------------------------------------------
  // Stage 2: accumulate
  // ---------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_d;

  assign acc_sum = acc_q + prod_q;

`ifdef MAC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic acc_ovf;

  // Signed overflow: both addends share a sign that the sum does not.
  assign acc_ovf = (acc_q[ACC_W-1] == prod_q[ACC_W-1]) &&
                   (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    acc_d = acc_sum;
    if (acc_ovf) begin
      acc_d = acc_q[ACC_W-1] ? $signed(ACC_MIN) : $signed(ACC_MAX);
    end
  end
`else
  assign acc_d = acc_sum;
`endif

  // ---------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] out_d;

`ifdef MAC_SATURATE_EN
  localparam logic [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [ACC_W-WIDTH:0] acc_hi;

  // acc_q fits WIDTH signed bits exactly when every bit from the output
  // sign position upward is a copy of the sign.
  assign acc_hi = acc_q[ACC_W-1:WIDTH-1];

  always_comb begin
    out_d = acc_q[WIDTH-1:0];
    if (!((acc_hi == '0) || (acc_hi == '1))) begin
      out_d = acc_q[ACC_W-1] ? OUT_MIN : OUT_MAX;
    end
  end
`else
  assign out_d = acc_q[WIDTH-1:0];
`endif

  // ---------------------------------------------------------------------
  // Registers: all cleared asynchronously so a mid-run reset discards any
  // product still in flight.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q   <= '0;
      acc_q    <= '0;
      data_out <= '0;
    end else begin
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      data_out <= out_d;
    end
  end

endmodule

// File: tb/tb_fixed_point_mac.sv
// tb/tb_fixed_point_mac.sv - directed self-checking bench for fixed_point_mac

module tb_fixed_point_mac;

  logic        clk;
  logic        rst;
  logic [31:0] data_in_a;
  logic [31:0] data_in_b;
  logic [31:0] data_out;

  int total;
  int bad;

  fixed_point_mac #(
    .WIDTH(32),
    .FRAC (16),
    .ACC_W(48)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in_a(data_in_a),
    .data_in_b(data_in_b),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    data_in_a = 32'h0;
    data_in_b = 32'h0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    data_in_a = 32'h0;
    data_in_b = 32'h0;
    for (int i = 0; i < 4; i++) begin
      data_in_a = $urandom;
      data_in_b = $urandom;
      tick();
      total++;
      if (data_out !== 32'h0) begin
        bad++;
        $display("FAIL reset_hold[%0d] got=%h want=%h", i, data_out, 32'h0);
      end
    end
    data_in_a = 32'h0;
    data_in_b = 32'h0;
    rst       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (data_out !== 32'h0) begin
        bad++;
        $display("FAIL reset_release[%0d] got=%h want=%h", i, data_out, 32'h0);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp [3];
    exp[0] = 32'h0002_0000;
    exp[1] = 32'h0004_0000;
    exp[2] = 32'h0006_0000;
    do_reset();
    data_in_a = 32'h0001_0000;
    data_in_b = 32'h0002_0000;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (data_out !== exp[i]) begin
        bad++;
        $display("FAIL basic[%0d] got=%h want=%h", i, data_out, exp[i]);
      end
    end
  endtask

  task automatic test_signed();
    logic [31:0] exp [2];
    exp[0] = 32'hFFFF_C000;
    exp[1] = 32'hFFFF_8000;
    do_reset();
    data_in_a = 32'hFFFF_0000;
    data_in_b = 32'h0000_4000;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (data_out !== exp[i]) begin
        bad++;
        $display("FAIL signed[%0d] got=%h want=%h", i, data_out, exp[i]);
      end
    end
  endtask

  // Each vector is applied for one cycle; the running sum is checked once it
  // has passed through the pipeline.
  task automatic test_rounding();
    logic [31:0] va  [4];
    logic [31:0] vb  [4];
    logic [31:0] exp [4];
    va[0] = 32'h0000_0001; vb[0] = 32'h0000_8000; exp[0] = 32'h0000_0001; // +0.5 lsb -> +1
    va[1] = 32'h0000_0001; vb[1] = 32'h0000_7FFF; exp[1] = 32'h0000_0001; // below half -> 0
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'h0000_8000; exp[2] = 32'h0000_0001; // -0.5 lsb -> 0
    va[3] = 32'hFFFF_FFFF; vb[3] = 32'h0000_8001; exp[3] = 32'h0000_0000; // just past -half -> -1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      data_in_a = va[i];
      data_in_b = vb[i];
      tick();
      data_in_a = 32'h0;
      data_in_b = 32'h0;
      tick();
      tick();
      total++;
      if (data_out !== exp[i]) begin
        bad++;
        $display("FAIL rounding[%0d] got=%h want=%h", i, data_out, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_max;
    logic [31:0] exp_min;
`ifdef MAC_SATURATE_EN
    exp_max = 32'h7FFF_FFFF;
    exp_min = 32'h7FFF_FFFF;
`else
    exp_max = 32'hFFFF_0000;
    exp_min = 32'h0000_0000;
`endif
    do_reset();
    data_in_a = 32'h7FFF_FFFF;
    data_in_b = 32'h7FFF_FFFF;
    tick();
    data_in_a = 32'h0;
    data_in_b = 32'h0;
    tick();
    tick();
    total++;
    if (data_out !== exp_max) begin
      bad++;
      $display("FAIL overflow_max got=%h want=%h", data_out, exp_max);
    end
    // Zero inputs must freeze the sum.
    tick();
    tick();
    total++;
    if (data_out !== exp_max) begin
      bad++;
      $display("FAIL overflow_freeze got=%h want=%h", data_out, exp_max);
    end

    // -32768.0 * -32768.0 rounds to exactly 2^46 in the accumulator.
    do_reset();
    data_in_a = 32'h8000_0000;
    data_in_b = 32'h8000_0000;
    tick();
    data_in_a = 32'h0;
    data_in_b = 32'h0;
    tick();
    tick();
    total++;
    if (data_out !== exp_min) begin
      bad++;
      $display("FAIL overflow_minmin got=%h want=%h", data_out, exp_min);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va  [4];
    logic [31:0] vb  [4];
    logic [31:0] cum [4];
    va[0] = 32'h0001_0000; vb[0] = 32'h0001_0000; cum[0] = 32'h0001_0000; // +1.0
    va[1] = 32'h0002_0000; vb[1] = 32'h0003_0000; cum[1] = 32'h0007_0000; // +6.0
    va[2] = 32'hFFFF_0000; vb[2] = 32'h0004_0000; cum[2] = 32'h0003_0000; // -4.0
    va[3] = 32'h0000_8000; vb[3] = 32'h0000_8000; cum[3] = 32'h0003_4000; // +0.25
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        data_in_a = va[k];
        data_in_b = vb[k];
      end else begin
        data_in_a = 32'h0;
        data_in_b = 32'h0;
      end
      tick();
      if (k >= 2) begin
        total++;
        if (data_out !== cum[k-2]) begin
          bad++;
          $display("FAIL back_to_back[%0d] got=%h want=%h", k-2, data_out, cum[k-2]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] exp_resume [4];
    exp_resume[0] = 32'h0000_0000;
    exp_resume[1] = 32'h0000_0000;
    exp_resume[2] = 32'h0001_0000;
    exp_resume[3] = 32'h0002_0000;
    do_reset();
    data_in_a = 32'h0001_0000;
    data_in_b = 32'h0001_0000;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (data_out !== 32'h0003_0000) begin
      bad++;
      $display("FAIL midrun_before got=%h want=%h", data_out, 32'h0003_0000);
    end
    // Pulse reset between edges; the clear must not wait for a clock.
    rst = 1'b0;
    #2;
    total++;
    if (data_out !== 32'h0) begin
      bad++;
      $display("FAIL midrun_async got=%h want=%h", data_out, 32'h0);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (data_out !== exp_resume[i]) begin
        bad++;
        $display("FAIL midrun_resume[%0d] got=%h want=%h", i, data_out, exp_resume[i]);
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    data_in_a = 32'h0;
    data_in_b = 32'h0;
    test_reset();
    test_basic();
    test_signed();
    test_rounding();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
